// File: rtl/regfile_rd_ctrl.sv
// regfile_rd_ctrl: 8x16 register file with a scoreboarded A/B operand read port.
// Reads of registers claimed by an in-flight writer wait until the write lands.
module regfile_rd_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              claim_en_i,
  input  logic [ADDR_W-1:0] claim_addr_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic              rd_ready_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   pend_q, pend_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, sa, sb;
  logic [DATA_W-1:0] da_q, da_d, db_q, db_d, byp_a, byp_b;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d, hit_a, hit_b, blk, cap;
  assign sa    = state_q == WAIT ? addr_a_q : rd_addr_a_i;
  assign sb    = state_q == WAIT ? addr_b_q : rd_addr_b_i;
  assign hit_a = wr_en_i && wr_addr_i == sa;
  assign hit_b = wr_en_i && wr_addr_i == sb;
  assign blk   = (pend_q[sa] && !hit_a) || (pend_q[sb] && !hit_b);
  assign byp_a = hit_a ? wr_data_i : regs_q[sa];
  assign byp_b = hit_b ? wr_data_i : regs_q[sb];
  assign cap   = (state_q == WAIT || rd_req_i) && !blk;
  always_comb begin
    pend_d = pend_q;
    if (wr_en_i) pend_d[wr_addr_i] = 1'b0;
    // a claim in the same cycle belongs to a later writer, so it wins
    if (claim_en_i) pend_d[claim_addr_i] = 1'b1;
  end
  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    cnt_d    = cnt_q;
    valid_d  = cap;
    da_d     = cap ? byp_a : da_q;
    db_d     = cap ? byp_b : db_q;
    if (state_q == IDLE && rd_req_i && blk) begin
      state_d  = WAIT;
      addr_a_d = rd_addr_a_i;
      addr_b_d = rd_addr_b_i;
    end else if (state_q == WAIT) begin
      state_d = blk ? WAIT : IDLE;
      cnt_d   = blk && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pend_q   <= '0;
      state_q  <= IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      da_q     <= '0;
      db_q     <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (wr_en_i) regs_q[wr_addr_i] <= wr_data_i;
      pend_q   <= pend_d;
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      da_q     <= da_d;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end
  assign rd_ready_o  = state_q == IDLE;
  assign rd_valid_o  = valid_q;
  assign rd_data_a_o = da_q;
  assign rd_data_b_o = db_q;
  assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_regfile_rd_ctrl.sv
// tb_regfile_rd_ctrl: directed stimulus, per-cycle comparison against a behavioural
// model of the register file / scoreboard, plus literal expectations at key points.
module tb_regfile_rd_ctrl;
  logic        clk = 0, rst_n = 1;
  logic        wr_en = 0, claim_en = 0, rd_req = 0;
  logic [2:0]  wr_addr = 0, claim_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
  logic [15:0] wr_data = 0;
  logic        rd_ready, rd_valid;
  logic [15:0] rd_data_a, rd_data_b;
  logic [7:0]  stall_cnt;
  int checks = 0, failures = 0;
  bit go = 0;

  regfile_rd_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .claim_en_i(claim_en), .claim_addr_i(claim_addr), .rd_req_i(rd_req),
    .rd_addr_a_i(rd_addr_a), .rd_addr_b_i(rd_addr_b), .rd_ready_o(rd_ready),
    .rd_valid_o(rd_valid), .rd_data_a_o(rd_data_a), .rd_data_b_o(rd_data_b),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  // model: one outstanding read that completes on the first edge none of its sources is blocked
  logic [15:0] m_reg [8];
  bit          m_pend [8];
  bit          m_busy, m_valid;
  int          m_a, m_b, m_cnt;
  logic [15:0] m_da, m_db;

  function automatic bit m_blocked(int x);
    return m_pend[x] && !(wr_en && wr_addr == x);
  endfunction
  function automatic logic [15:0] m_value(int x);
    return (wr_en && wr_addr == x) ? wr_data : m_reg[x];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
      m_busy = 0; m_valid = 0; m_cnt = 0; m_da = 0; m_db = 0; m_a = 0; m_b = 0;
    end else begin
      bit waited;
      waited = m_busy;
      m_valid = 0;
      if (!m_busy && rd_req) begin m_busy = 1; m_a = rd_addr_a; m_b = rd_addr_b; end
      if (m_busy) begin
        if (!m_blocked(m_a) && !m_blocked(m_b)) begin
          m_da = m_value(m_a); m_db = m_value(m_b); m_valid = 1; m_busy = 0;
        end else if (waited && m_cnt < 255) m_cnt++;
      end
      if (wr_en) begin m_reg[wr_addr] = wr_data; m_pend[wr_addr] = 0; end
      if (claim_en) m_pend[claim_addr] = 1;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (go && rst_n) begin
    chk("cyc_ready", rd_ready, !m_busy);
    chk("cyc_valid", rd_valid, m_valid);
    chk("cyc_data_a", rd_data_a, m_da);
    chk("cyc_data_b", rd_data_b, m_db);
    chk("cyc_stall", stall_cnt, m_cnt);
  end

  task automatic drive(bit we, int wa, logic [15:0] wd, bit ce, int ca, bit rq, int a, int b);
    wr_en = we; wr_addr = wa; wr_data = wd; claim_en = ce; claim_addr = ca;
    rd_req = rq; rd_addr_a = a; rd_addr_b = b;
    @(posedge clk); #1;
  endtask
  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1; go = 1;
    chk("rst_ready", rd_ready, 1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_a", rd_data_a, 0);
    chk("rst_cnt", stall_cnt, 0);
    drive(1, 3, 16'h1234, 0, 0, 0, 0, 0);
    drive(1, 5, 16'hBEEF, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 3, 5);
    chk("rd_valid", rd_valid, 1);
    chk("rd_a", rd_data_a, 16'h1234);
    chk("rd_b", rd_data_b, 16'hBEEF);
    chk("rd_ready", rd_ready, 1);
    drive(1, 2, 16'hA5A5, 0, 0, 1, 2, 2);
    chk("byp_valid", rd_valid, 1);
    chk("byp_a", rd_data_a, 16'hA5A5);
    chk("byp_b", rd_data_b, 16'hA5A5);
    idle();
    chk("hold_a", rd_data_a, 16'hA5A5);
    drive(0, 0, 0, 1, 4, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 4, 0);
    chk("stall_ready", rd_ready, 0);
    repeat (3) idle();
    chk("stall_novalid", rd_valid, 0);
    drive(1, 4, 16'h0F0F, 0, 0, 0, 0, 0);
    chk("stall_valid", rd_valid, 1);
    chk("stall_a", rd_data_a, 16'h0F0F);
    chk("stall_cnt", stall_cnt, 3);
    drive(1, 6, 16'h1111, 1, 6, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 6, 6);
    idle();
    chk("cw_wait", rd_ready, 0);
    drive(1, 6, 16'h2222, 0, 0, 0, 0, 0);
    chk("cw_valid", rd_valid, 1);
    chk("cw_a", rd_data_a, 16'h2222);
    drive(0, 0, 0, 1, 7, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 7, 0);
    repeat (300) idle();
    chk("sat_cnt", stall_cnt, 255);
    drive(1, 7, 16'h7777, 0, 0, 0, 0, 0);
    chk("sat_valid", rd_valid, 1);
    chk("sat_a", rd_data_a, 16'h7777);
    chk("sat_b", rd_data_b, 16'h0000);
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 1);
    repeat (2) idle();
    #2 rst_n = 0;
    #1;
    chk("arst_ready", rd_ready, 1);
    chk("arst_valid", rd_valid, 0);
    chk("arst_a", rd_data_a, 0);
    chk("arst_cnt", stall_cnt, 0);
    @(posedge clk); #1 rst_n = 1;
    drive(0, 0, 0, 0, 0, 1, 1, 3);
    chk("post_valid", rd_valid, 1);
    chk("post_a", rd_data_a, 0);
    chk("post_b", rd_data_b, 0);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
